tx_scheduler: RTL

TX_SCHEDULER -- requirements
Module: tx_scheduler

---
 rtl/tx_scheduler_pkg.sv | 34 +++
 rtl/tx_scheduler_if.sv | 38 +++
 rtl/tx_scheduler_rr_arb2.sv | 48 ++++
 rtl/tx_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tx_sched_pkg
// Shared types for the transmit scheduler and its round-robin arbiter.
//   state_t : scheduler FSM states
//   grant_t : which requester won the most recent arbitration
//   kind_t  : what the byte currently in flight is (header, ADC payload, GEN)
// ---------------------------------------------------------------------------
package tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    A_FETCH = 3'd2,
    A_LOAD  = 3'd3,
    G_FETCH = 3'd4,
    G_LOAD  = 3'd5,
    SEND    = 3'd6,
    WAIT    = 3'd7
  } state_t;

  typedef enum logic {
    GRANT_ADC = 1'b0,
    GRANT_GEN = 1'b1
  } grant_t;

  // The WAIT exit decision depends on what was just sent, so the byte
  // class is remembered from the moment it is chosen until WAIT ends.
  typedef enum logic [1:0] {
    KIND_HDR = 2'd0,
    KIND_ADC = 2'd1,
    KIND_GEN = 2'd2
  } kind_t;

endpackage

// File: rtl/tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// tx_scheduler_if
// Bundles the two FIFO read ports, the UART transmitter handshake and the
// status outputs of the scheduler.
//   master : the scheduler side (drives read strobes, TxStart/TxData, status)
//   slave  : the environment side (FIFOs and transmitter)
// Signals:
//   AdcEmpty/AdcData/AdcRd : ADC FIFO, data valid the cycle after AdcRd
//   GenEmpty/GenData/GenRd : general FIFO, data valid the cycle after GenRd
//   TxBusy/TxStart/TxData  : transmitter handshake
//   StreamActive           : high for the duration of an ADC burst
//   AdcByteCount           : running count of ADC payload bytes sent
// ---------------------------------------------------------------------------
interface tx_scheduler_if;

  logic        AdcEmpty;
  logic [7:0]  AdcData;
  logic        AdcRd;
  logic        GenEmpty;
  logic [7:0]  GenData;
  logic        GenRd;
  logic        TxBusy;
  logic        TxStart;
  logic [7:0]  TxData;
  logic        StreamActive;
  logic [15:0] AdcByteCount;

  modport master (
    input  AdcEmpty, AdcData, GenEmpty, GenData, TxBusy,
    output AdcRd, GenRd, TxStart, TxData, StreamActive, AdcByteCount
  );

  modport slave (
    output AdcEmpty, AdcData, GenEmpty, GenData, TxBusy,
    input  AdcRd, GenRd, TxStart, TxData, StreamActive, AdcByteCount
  );

endinterface

// File: rtl/tx_scheduler_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. The grant is purely combinational;
// the last_grant register only advances when the caller says an
// arbitration is actually being taken (update high).
// Ports:
//   clk, rst   : clock and async active-high reset
//   adc_req    : ADC requester wants service
//   gen_req    : general requester wants service
//   update     : accept the current grant and remember the winner
//   grant_adc  : ADC wins this arbitration
//   grant_gen  : GEN wins this arbitration
// ---------------------------------------------------------------------------
module rr_arb2
  import tx_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adc_req,
  input  logic gen_req,
  input  logic update,
  output logic grant_adc,
  output logic grant_gen
);

  grant_t last_grant;

  // ADC wins when it is alone or when GEN had the previous turn; GEN takes
  // whatever ADC does not. The two grants are mutually exclusive by design.
  always_comb begin
    grant_adc = adc_req && (!gen_req || (last_grant == GRANT_GEN));
    grant_gen = gen_req && !grant_adc;
  end

  // Reset favours ADC on the very first contested arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_GEN;
    end else if (update) begin
      if (grant_adc) begin
        last_grant <= GRANT_ADC;
      end else if (grant_gen) begin
        last_grant <= GRANT_GEN;
      end
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// ---------------------------------------------------------------------------
// tx_scheduler
// Feeds a single UART transmitter from two FIFOs. ADC data goes out in
// framed bursts (HDR_BYTE followed by up to BURST_LEN payload bytes);
// general-FIFO bytes go out one at a time between bursts. The two sources
// alternate round-robin whenever both are waiting.
// Parameters:
//   BURST_LEN : maximum ADC payload bytes per burst (1..255)
//   HDR_BYTE  : framing byte sent before each ADC burst
// Ports:
//   Clock, Reset : system clock, async active-high reset
//   bus          : tx_scheduler_if.master (FIFO reads, transmitter, status)
// ---------------------------------------------------------------------------
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int         BURST_LEN = 16,
  parameter logic [7:0] HDR_BYTE  = 8'hA5
)(
  input  logic          Clock,
  input  logic          Reset,
  tx_scheduler_if.master bus
);

  localparam logic [8:0] BURST_LIMIT = 9'(BURST_LEN);

  state_t      state;
  state_t      next_state;
  kind_t       kind;
  logic [7:0]  burst_cnt;
  logic [8:0]  cnt_next;
  logic [7:0]  tx_data;
  logic [15:0] adc_byte_count;
  logic        stream_active;
  logic        adc_rd;
  logic        gen_rd;
  logic        tx_start;
  logic        adc_rd_q;
  logic        gen_rd_q;
  logic        wait_first;
  logic        grant_adc;
  logic        grant_gen;

  // Arbitration is only consumed while sitting in IDLE; requests that show
  // up mid-burst simply wait for the next IDLE visit.
  rr_arb2 u_arb (
    .clk       (Clock),
    .rst       (Reset),
    .adc_req   (!bus.AdcEmpty),
    .gen_req   (!bus.GenEmpty),
    .update    (state == IDLE),
    .grant_adc (grant_adc),
    .grant_gen (grant_gen)
  );

  // Burst count as it will be once the byte now in WAIT is retired; only
  // ADC payload bytes count toward the burst length, never the header.
  assign cnt_next = {1'b0, burst_cnt} + {8'd0, (kind == KIND_ADC)};

  // Next-state and strobe decode. Every state that leads into SEND holds
  // off while the transmitter is busy, and SEND itself only fires when the
  // transmitter is free, so TxStart can never overlap TxBusy. Fetch states
  // re-check Empty so a read strobe never hits an empty FIFO.
  always_comb begin
    next_state = state;
    adc_rd     = 1'b0;
    gen_rd     = 1'b0;
    tx_start   = 1'b0;
    case (state)
      IDLE: begin
        if (grant_adc) begin
          next_state = HDR;
        end else if (grant_gen) begin
          next_state = G_FETCH;
        end
      end
      HDR: begin
        if (!bus.TxBusy) begin
          next_state = SEND;
        end
      end
      A_FETCH: begin
        if (bus.AdcEmpty) begin
          next_state = IDLE;
        end else begin
          adc_rd     = 1'b1;
          next_state = A_LOAD;
        end
      end
      A_LOAD: begin
        if (!bus.TxBusy) begin
          next_state = SEND;
        end
      end
      G_FETCH: begin
        if (bus.GenEmpty) begin
          next_state = IDLE;
        end else begin
          gen_rd     = 1'b1;
          next_state = G_LOAD;
        end
      end
      G_LOAD: begin
        if (!bus.TxBusy) begin
          next_state = SEND;
        end
      end
      SEND: begin
        if (!bus.TxBusy) begin
          tx_start   = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        // The transmitter raises TxBusy a cycle after TxStart, so the
        // first WAIT cycle must not treat a low TxBusy as "done".
        if (!wait_first && !bus.TxBusy) begin
          if ((kind != KIND_GEN) && (cnt_next < BURST_LIMIT) && !bus.AdcEmpty) begin
            next_state = A_FETCH;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register plus the one-cycle-delayed read strobes, which mark the
  // single cycle in which the FIFO data output is known to be valid.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      adc_rd_q   <= 1'b0;
      gen_rd_q   <= 1'b0;
      wait_first <= 1'b0;
    end else begin
      state      <= next_state;
      adc_rd_q   <= adc_rd;
      gen_rd_q   <= gen_rd;
      wait_first <= tx_start;
    end
  end

  // Datapath: byte class tracking, the transmit data register and the
  // burst/total counters. TxData is only loaded in HDR or in the load state
  // on the cycle right after a read, so it stays put while waiting.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      kind           <= KIND_HDR;
      burst_cnt      <= 8'd0;
      tx_data        <= 8'd0;
      adc_byte_count <= 16'd0;
    end else begin
      if (state == IDLE && grant_adc) begin
        kind      <= KIND_HDR;
        burst_cnt <= 8'd0;
      end else if (state == IDLE && grant_gen) begin
        kind <= KIND_GEN;
      end
      if (state == HDR) begin
        tx_data <= HDR_BYTE;
      end
      if (adc_rd) begin
        kind <= KIND_ADC;
      end
      if (state == A_LOAD && adc_rd_q) begin
        tx_data <= bus.AdcData;
      end
      if (state == G_LOAD && gen_rd_q) begin
        tx_data <= bus.GenData;
      end
      if (state == WAIT && next_state != WAIT && kind == KIND_ADC) begin
        burst_cnt      <= cnt_next[7:0];
        adc_byte_count <= adc_byte_count + 16'd1;
      end
    end
  end

  // StreamActive rises together with the header's SEND and falls on the
  // way back to IDLE, covering the whole framed burst.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stream_active <= 1'b0;
    end else if (next_state == IDLE) begin
      stream_active <= 1'b0;
    end else if (state == HDR && next_state == SEND) begin
      stream_active <= 1'b1;
    end
  end

  assign bus.AdcRd        = adc_rd;
  assign bus.GenRd        = gen_rd;
  assign bus.TxStart      = tx_start;
  assign bus.TxData       = tx_data;
  assign bus.StreamActive = stream_active;
  assign bus.AdcByteCount = adc_byte_count;

endmodule
